// File: rtl/rf_synth_prog.sv
// Programs the RF synthesizer over a 3-wire bus for each hop request, then waits for PLL settle and pulses fkset_p.
// Request at cycle N yields fkset_p at N+2+48*SCLK_DIV+2*SCLK_DIV+SETTLE_CYC; there is no backpressure, newer requests preempt.
module rf_synth_prog #(
  parameter int          SCLK_DIV   = 3,
  parameter int          SETTLE_CYC = 900,
  parameter int          BASE_MHZ   = 2402,
  parameter logic [3:0]  REG_ADDR   = 4'h1
) (
  input  logic       clk_6M,
  input  logic       rstz,
  input  logic       fk_chg_p,
  input  logic [6:0] fk,
  input  logic       tx_mode,
  output logic       synth_sclk,
  output logic       synth_sdata,
  output logic       synth_le,
  output logic       fkset_p,
  output logic       fk_err_p,
  output logic       busy
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] SHIFT  = 3'd2;
  localparam logic [2:0] LATCH  = 3'd3;
  localparam logic [2:0] SETTLE = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  localparam int DIV_W = (2 * SCLK_DIV > 1) ? $clog2(2 * SCLK_DIV) : 1;
  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * SCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SCLK_DIV);
  localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYC - 1);
  localparam logic [11:0]      BASE_F   = 12'(BASE_MHZ);
  localparam logic [6:0]       FK_MAX   = 7'd78;

  logic [2:0]       state_q, state_d;
  logic [6:0]       fk_q, fk_d;
  logic             tx_q, tx_d;
  logic             pend_q, pend_d;
  logic [23:0]      word_q, word_d;
  logic [4:0]       bit_q, bit_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [SET_W-1:0] set_q, set_d;

  logic             fk_ok;
  logic             div_last;
  logic [11:0]      freq;

  assign fk_ok    = (fk_q <= FK_MAX);
  assign div_last = (div_q == DIV_LAST);
  assign freq     = BASE_F + {5'd0, fk_q};

  always_comb begin
    state_d = state_q;
    fk_d    = fk_q;
    tx_d    = tx_q;
    pend_d  = pend_q;
    word_d  = word_q;
    bit_d   = bit_q;
    div_d   = div_q;
    set_d   = set_q;

    // Every state accepts a new channel; the latest request always wins.
    if (fk_chg_p) begin
      fk_d = fk;
      tx_d = tx_mode;
    end

    case (state_q)
      IDLE: begin
        if (fk_chg_p) begin
          state_d = LOAD;
        end
      end

      LOAD: begin
        if (!fk_ok) begin
          pend_d  = 1'b0;
          state_d = fk_chg_p ? LOAD : IDLE;
        end else begin
          pend_d  = fk_chg_p;
          word_d  = {REG_ADDR, tx_q, fk_q, freq};
          bit_d   = 5'd23;
          div_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (fk_chg_p) begin
          pend_d = 1'b1;
        end
        if (div_last) begin
          div_d = '0;
          if (bit_q == 5'd0) begin
            state_d = LATCH;
          end else begin
            bit_d = bit_q - 5'd1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      LATCH: begin
        if (fk_chg_p) begin
          pend_d = 1'b1;
        end
        if (div_last) begin
          div_d = '0;
          // A request seen while the word was going out restarts programming instead of settling.
          if (pend_q || fk_chg_p) begin
            pend_d  = 1'b0;
            state_d = LOAD;
          end else begin
            set_d   = SET_LOAD;
            state_d = SETTLE;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      SETTLE: begin
        if (fk_chg_p) begin
          state_d = LOAD;
        end else if (set_q == '0) begin
          state_d = DONE;
        end else begin
          set_d = set_q - SET_W'(1);
        end
      end

      DONE: begin
        state_d = fk_chg_p ? LOAD : IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_6M) begin
    if (!rstz) begin
      state_q <= IDLE;
      fk_q    <= '0;
      tx_q    <= 1'b0;
      pend_q  <= 1'b0;
      word_q  <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      set_q   <= '0;
    end else begin
      state_q <= state_d;
      fk_q    <= fk_d;
      tx_q    <= tx_d;
      pend_q  <= pend_d;
      word_q  <= word_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      set_q   <= set_d;
    end
  end

  // Outputs decode registered state only, so a reset clears them on the following cycle.
  assign synth_sclk  = (state_q == SHIFT) && (div_q >= DIV_HALF);
  assign synth_sdata = (state_q == SHIFT) && word_q[bit_q];
  assign synth_le    = (state_q == LATCH);
  assign fkset_p     = (state_q == DONE);
  assign fk_err_p    = (state_q == LOAD) && !fk_ok;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_rf_synth_prog.sv
// Directed bench for rf_synth_prog: expected words and pulse cycles are queued at request time and checked as the DUT emits them.
module tb_rf_synth_prog;

  logic       clk_6M;
  logic       rstz;
  logic       fk_chg_p;
  logic [6:0] fk;
  logic       tx_mode;
  logic       synth_sclk;
  logic       synth_sdata;
  logic       synth_le;
  logic       fkset_p;
  logic       fk_err_p;
  logic       busy;

  rf_synth_prog dut (
    .clk_6M      (clk_6M),
    .rstz        (rstz),
    .fk_chg_p    (fk_chg_p),
    .fk          (fk),
    .tx_mode     (tx_mode),
    .synth_sclk  (synth_sclk),
    .synth_sdata (synth_sdata),
    .synth_le    (synth_le),
    .fkset_p     (fkset_p),
    .fk_err_p    (fk_err_p),
    .busy        (busy)
  );

  initial clk_6M = 1'b0;
  always #5 clk_6M = ~clk_6M;

  typedef struct {
    logic [23:0] w;
    int          le_cyc;
  } exp_word_t;

  exp_word_t   exp_words[$];
  int          exp_fkset[$];
  int          exp_err[$];

  int          checks;
  int          errors;
  int          cyc;
  int          nbits;
  int          le_start;
  logic [23:0] shreg;
  logic        prev_sclk;
  logic        prev_sdata;
  logic        prev_le;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [23:0] mk_word(input logic [6:0] f, input logic t);
    logic [11:0] fr;
    fr = 12'(2402 + int'(f));
    return {4'h1, t, f, fr};
  endfunction

  // Samples DUT outputs once per cycle, 1 time unit after the rising edge.
  task automatic monitor();
    exp_word_t e;
    int        c;
    if (synth_sclk && !prev_sclk) begin
      shreg = {shreg[22:0], synth_sdata};
      nbits++;
    end
    if (synth_sclk && prev_sclk) chk("sdata_stable", 32'(synth_sdata), 32'(prev_sdata));
    if (synth_le && !prev_le) begin
      if (exp_words.size() == 0) begin
        chk("le_unexpected", 32'(synth_le), 32'd0);
      end else begin
        e = exp_words.pop_front();
        chk("word", 32'(shreg), 32'(e.w));
        chk("nbits", 32'(nbits), 32'd24);
        chk("le_cycle", cyc, e.le_cyc);
      end
      nbits    = 0;
      le_start = cyc;
    end
    if (!synth_le && prev_le) chk("le_width", cyc - le_start, 32'd6);
    if (fkset_p) begin
      if (exp_fkset.size() == 0) chk("fkset_unexpected", 32'(fkset_p), 32'd0);
      else begin
        c = exp_fkset.pop_front();
        chk("fkset_cycle", cyc, c);
      end
    end
    if (fk_err_p) begin
      if (exp_err.size() == 0) chk("err_unexpected", 32'(fk_err_p), 32'd0);
      else begin
        c = exp_err.pop_front();
        chk("err_cycle", cyc, c);
      end
    end
    if (fkset_p || fk_err_p) chk("pulse_excl", 32'(fkset_p & fk_err_p), 32'd0);
    prev_sclk  = synth_sclk;
    prev_sdata = synth_sdata;
    prev_le    = synth_le;
  endtask

  task automatic tick();
    @(posedge clk_6M);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic req(input logic [6:0] f, input logic t);
    fk       = f;
    tx_mode  = t;
    fk_chg_p = 1'b1;
    tick();
    fk_chg_p = 1'b0;
  endtask

  task automatic queues_empty(input string tag);
    chk({tag, "_words_left"}, 32'(exp_words.size()), 32'd0);
    chk({tag, "_fkset_left"}, 32'(exp_fkset.size()), 32'd0);
    chk({tag, "_err_left"},   32'(exp_err.size()),   32'd0);
  endtask

  task automatic nominal_fk0(input string tag);
    exp_word_t e;
    int        n;
    n = cyc;
    e.w = 24'h180962; e.le_cyc = n + 146;
    exp_words.push_back(e);
    exp_fkset.push_back(n + 1052);
    req(7'd0, 1'b1);
    chk({tag, "_busy_load"}, 32'(busy), 32'd1);
    run_to(n + 1052);
    chk({tag, "_busy_done"}, 32'(busy), 32'd1);
    tick();
    chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
    queues_empty(tag);
  endtask

  initial begin
    exp_word_t e;
    int        n;
    checks     = 0;
    errors     = 0;
    cyc        = 0;
    nbits      = 0;
    le_start   = 0;
    shreg      = '0;
    prev_sclk  = 1'b0;
    prev_sdata = 1'b0;
    prev_le    = 1'b0;
    rstz       = 1'b0;
    fk_chg_p   = 1'b0;
    fk         = '0;
    tx_mode    = 1'b0;

    repeat (3) tick();
    chk("rst_sclk",  32'(synth_sclk),  32'd0);
    chk("rst_sdata", 32'(synth_sdata), 32'd0);
    chk("rst_le",    32'(synth_le),    32'd0);
    chk("rst_fkset", 32'(fkset_p),     32'd0);
    chk("rst_err",   32'(fk_err_p),    32'd0);
    chk("rst_busy",  32'(busy),        32'd0);
    rstz = 1'b1;
    repeat (3) tick();

    // Test 1: fk=0 TX
    nominal_fk0("t1");
    repeat (5) tick();

    // Test 2: fk=78 RX, top of band
    n = cyc;
    e.w = 24'h14E9B0; e.le_cyc = n + 146;
    exp_words.push_back(e);
    exp_fkset.push_back(n + 1052);
    req(7'd78, 1'b0);
    run_to(n + 1060);
    queues_empty("t2");

    // Test 3: fk=79 rejected
    n = cyc;
    exp_err.push_back(n + 1);
    req(7'd79, 1'b0);
    chk("t3_busy_load", 32'(busy), 32'd1);
    tick();
    chk("t3_busy_idle", 32'(busy), 32'd0);
    run_to(n + 200);
    chk("t3_no_bits", 32'(nbits), 32'd0);
    queues_empty("t3");

    // Test 4: retrigger mid-SHIFT
    n = cyc;
    e.w = mk_word(7'd5, 1'b1);  e.le_cyc = n + 146;
    exp_words.push_back(e);
    e.w = mk_word(7'd10, 1'b0); e.le_cyc = n + 297;
    exp_words.push_back(e);
    exp_fkset.push_back(n + 1203);
    req(7'd5, 1'b1);
    run_to(n + 50);
    req(7'd10, 1'b0);
    run_to(n + 1210);
    queues_empty("t4");

    // Test 5: retrigger during SETTLE
    n = cyc;
    e.w = mk_word(7'd3, 1'b1); e.le_cyc = n + 146;
    exp_words.push_back(e);
    e.w = mk_word(7'd4, 1'b1); e.le_cyc = n + 646;
    exp_words.push_back(e);
    exp_fkset.push_back(n + 1552);
    req(7'd3, 1'b1);
    run_to(n + 500);
    req(7'd4, 1'b1);
    run_to(n + 1560);
    queues_empty("t5");

    // Test 6: reset mid-SHIFT abandons the word
    n = cyc;
    req(7'd0, 1'b1);
    run_to(n + 60);
    rstz = 1'b0;
    tick();
    rstz = 1'b1;
    chk("t6_sclk",  32'(synth_sclk),  32'd0);
    chk("t6_sdata", 32'(synth_sdata), 32'd0);
    chk("t6_le",    32'(synth_le),    32'd0);
    chk("t6_fkset", 32'(fkset_p),     32'd0);
    chk("t6_err",   32'(fk_err_p),    32'd0);
    chk("t6_busy",  32'(busy),        32'd0);
    nbits = 0;
    shreg = '0;
    run_to(n + 1200);
    chk("t6_no_bits", 32'(nbits), 32'd0);
    queues_empty("t6");
    nominal_fk0("t6b");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
